oled_text_feeder: RTL and testbench
===================================

# oled_text_feeder

Upstream character stage for the OLED text display. Accepts a byte stream (typically UART RX or a debug source) through a valid/ready port, buffers it in a small FIFO, and interprets a minimal terminal control set (LF, FF). It then drives the OLED controller's `data` / `data_valid` / `done` byte handshake one character at a time, tracking cursor position on the COLS×ROWS screen.

## Interface

- `DEPTH`, 16: FIFO entries; power of 2, ≥2.
- `COLS`, 16: characters per display line.
- `ROWS`, 4: display lines. `POSW = $clog2(COLS*ROWS)`.
- `i_clk`  in  1  system clock (100 MHz onboard).
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_data`  in  8  upstream byte.
- `i_valid`  in  1  upstream byte valid.
- `o_ready`  out  1  FIFO can accept; a byte is written on an edge with `i_valid && o_ready`.
- `o_data`  out  8  character to the OLED controller (its `data`).
- `o_data_valid`  out  1  character request (controller `data_valid`).
- `i_done`  in  1  controller `done`.
- `o_pos`  out  POSW  cursor position 0..COLS*ROWS-1; the next character lands here.
- `o_level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

- **FIFO:** write-when-`o_ready`; `o_ready = !full`, registered; it is low during reset.
- **Character classes** (decided at DECODE):
  - Printable `0x20`–`0x7E`: sent as-is.
  - LF `0x0A`: if `col = pos % COLS` is 0, nothing is sent. Otherwise `COLS-col` spaces (`0x20`) are sent.
  - FF `0x0C`: if `pos` is 0, nothing is sent. Otherwise `COLS*ROWS-pos` spaces are sent.
  - All other bytes: popped and dropped, nothing sent.
- **Padding:** uses `pad_cnt`, width POSW+1. The FIFO is not popped while `pad_cnt != 0`.
- **FSM:**
  - IDLE:
    - `pad_cnt != 0` → REQ with `o_data = 0x20`.
    - Else FIFO non-empty → pop, latch byte, go to DECODE.
  - DECODE:
    - Printable → REQ with `o_data = byte`.
    - LF/FF needing pad → load `pad_cnt = N`, `o_data = 0x20`, go to REQ.
    - Else → IDLE.
  - REQ: wait for `i_done == 0`, then set `o_data_valid = 1` and go to ACK. `o_data` is held stable.
  - ACK: on `i_done == 1`, clear `o_data_valid`, advance `pos` (63→0 wrap, i.e. COLS*ROWS-1→0), decrement `pad_cnt` if non-zero, and go to IDLE.
- **Reset values:** `o_data = 0x00`, `o_data_valid = 0`, `o_pos = 0`, `o_level = 0`, `o_ready = 0`, state IDLE, `pad_cnt = 0`.
- **Reset mid-transfer:** all state clears on the next edge with `i_rst_n` low. `o_data_valid` drops immediately, and FIFO contents are discarded.

## Timing

- `o_ready` is 1 on the first edge after `i_rst_n` rises, provided the FIFO is not full.
- **Latency:** byte written at edge N with FSM idle and `i_done` low gives `o_data_valid` high after edge N+3 (IDLE→DECODE N+1, DECODE→REQ N+2, REQ→ACK N+3).
- `o_data_valid` stays high until the edge after `i_done` is seen high; `o_data` never changes while valid is high.
- Back-to-back characters: at least one cycle with `o_data_valid` low between requests.
- **Simultaneous write and pop:** allowed; `o_level` is unchanged.
- **Full FIFO:** `o_ready` goes low the edge the last slot fills, and rises the edge after a pop.
- `i_done` held high in IDLE/REQ: the feeder waits in REQ indefinitely with valid low.

## Structure

- Shared header `oled_defs.vh`:
  - OLED_COLS / OLED_ROWS defaults.
  - Character constants CH_LF, CH_FF, CH_SPACE, CH_PRINT_MIN/MAX.
  - FSM state encodings.
- Sub-module `sync_fifo` (DEPTH, WIDTH=8; registered full/empty, level output). It is reusable for the UART path.
- FSM, cursor and pad counter live in `oled_text_feeder`.

## Test plan

- **Single char:** after reset, write `0x41` with a controller model that pulses `done` 5 cycles after valid. Expected: `o_data = 0x41`, valid at N+3, `o_pos` 0→1.
- **LF padding:** write "AB", `0x0A`. Expected: 0x41, 0x42, then 14× `0x20`, with `o_pos = 16`. Then write LF at `pos = 16`: nothing is sent.
- **FF at pos 5:** expect 59 spaces and `o_pos = 0`. Also verify wrap: 64 printables from pos 0 give `o_pos = 0`.
- **Dropped controls:** write `0x07`, `0x1B`, `0x7F`. Expected: no `o_data_valid`, `o_level` returns to 0, `o_pos` unchanged.
- **Backpressure:** hold `done` low-then-stuck, write 17 bytes with DEPTH=16. Expected: `o_ready` low after 16 (or 17 if one was popped), no loss, order preserved on release.
- **Reset mid-ACK:** assert `i_rst_n = 0` while valid is high. Expected: valid 0 and `o_pos` 0 on the next edge, `o_level = 0`, and the first post-reset write is handled normally.

Source files
------------

// File: rtl/oled_text_feeder_pkg.sv
// Shared constants, state encodings and character classification for the OLED text feeder.
package oled_text_feeder_pkg;

  localparam int OLED_COLS = 16;
  localparam int OLED_ROWS = 4;

  localparam logic [7:0] CH_LF        = 8'h0A;
  localparam logic [7:0] CH_FF        = 8'h0C;
  localparam logic [7:0] CH_SPACE     = 8'h20;
  localparam logic [7:0] CH_PRINT_MIN = 8'h20;
  localparam logic [7:0] CH_PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_REQ,
    ST_ACK
  } feeder_state_t;

  typedef enum logic [1:0] {
    CLS_PRINT,
    CLS_LF,
    CLS_FF,
    CLS_DROP
  } char_class_t;

  function automatic char_class_t classify(input logic [7:0] b);
    if (b >= CH_PRINT_MIN && b <= CH_PRINT_MAX) return CLS_PRINT;
    else if (b == CH_LF)                        return CLS_LF;
    else if (b == CH_FF)                        return CLS_FF;
    else                                        return CLS_DROP;
  endfunction

endpackage

// File: rtl/oled_text_feeder_if.sv
// Byte-stream input plus OLED controller character handshake, with cursor and FIFO status.
interface oled_text_feeder_if #(
  parameter int POSW = 6,
  parameter int LEVW = 5
) ();

  logic [7:0]      data;
  logic            valid;
  logic            ready;
  logic [7:0]      oled_data;
  logic            oled_data_valid;
  logic            done;
  logic [POSW-1:0] pos;
  logic [LEVW-1:0] level;

  modport master (
    output data, valid, done,
    input  ready, oled_data, oled_data_valid, pos, level
  );

  modport slave (
    input  data, valid, done,
    output ready, oled_data, oled_data_valid, pos, level
  );

endinterface

// File: rtl/oled_text_feeder_sync_fifo.sv
// Synchronous FIFO with registered ready/empty flags and occupancy; reusable for the UART path.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_ready,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_empty;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;

  assign w_push = i_wr && r_ready;
  assign w_pop  = i_rd && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  // Flags are computed from the next occupancy so they track the level without a cycle of lag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_ready <= (w_level_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && i_rst_n) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_ready = r_ready;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/oled_text_feeder.sv
// Buffers an upstream byte stream, expands LF/FF into space padding and feeds the OLED
// controller one character at a time while tracking the cursor position.
module oled_text_feeder
  import oled_text_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int COLS  = OLED_COLS,
  parameter int ROWS  = OLED_ROWS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  oled_text_feeder_if.slave   io_bus
);

  localparam int TOTAL = COLS * ROWS;
  localparam int POSW  = $clog2(TOTAL);
  localparam int PADW  = POSW + 1;
  localparam int LEVW  = $clog2(DEPTH) + 1;

  logic [7:0]      w_fifo_dout;
  logic            w_fifo_empty;
  logic            w_fifo_ready;
  logic [LEVW-1:0] w_fifo_level;
  logic            w_pop;

  feeder_state_t   r_state;
  feeder_state_t   w_state_nxt;
  logic [7:0]      r_byte;
  logic [7:0]      w_byte_nxt;
  logic [7:0]      r_data;
  logic [7:0]      w_data_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic [POSW-1:0] r_pos;
  logic [POSW-1:0] w_pos_nxt;
  logic [PADW-1:0] r_pad;
  logic [PADW-1:0] w_pad_nxt;
  logic [POSW-1:0] w_col;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (io_bus.valid),
    .i_wdata (io_bus.data),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_dout),
    .o_ready (w_fifo_ready),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // Widened before the modulo so a single-row screen (COLS == TOTAL) never divides by zero.
  assign w_col = POSW'(PADW'(r_pos) % PADW'(COLS));

  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_pos_nxt   = r_pos;
    w_pad_nxt   = r_pad;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_pad != '0) begin
          w_data_nxt  = CH_SPACE;
          w_state_nxt = ST_REQ;
        end else if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_byte_nxt  = w_fifo_dout;
          w_state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        w_state_nxt = ST_IDLE;
        case (classify(r_byte))
          CLS_PRINT: begin
            w_data_nxt  = r_byte;
            w_state_nxt = ST_REQ;
          end
          CLS_LF: begin
            if (w_col != '0) begin
              w_pad_nxt   = PADW'(COLS) - PADW'(w_col);
              w_data_nxt  = CH_SPACE;
              w_state_nxt = ST_REQ;
            end
          end
          CLS_FF: begin
            if (r_pos != '0) begin
              w_pad_nxt   = PADW'(TOTAL) - PADW'(r_pos);
              w_data_nxt  = CH_SPACE;
              w_state_nxt = ST_REQ;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end

      // A controller still asserting done from the previous character holds us here.
      ST_REQ: begin
        if (!io_bus.done) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end

      ST_ACK: begin
        if (io_bus.done) begin
          w_valid_nxt = 1'b0;
          w_pos_nxt   = (r_pos == POSW'(TOTAL - 1)) ? '0 : r_pos + POSW'(1);
          if (r_pad != '0) w_pad_nxt = r_pad - PADW'(1);
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_byte  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pos   <= '0;
      r_pad   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_byte  <= w_byte_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_pos   <= w_pos_nxt;
      r_pad   <= w_pad_nxt;
    end
  end

  assign io_bus.ready           = w_fifo_ready;
  assign io_bus.level           = w_fifo_level;
  assign io_bus.oled_data       = r_data;
  assign io_bus.oled_data_valid = r_valid;
  assign io_bus.pos             = r_pos;

endmodule

// File: tb/tb_oled_text_feeder.sv
// Directed and randomized checks of oled_text_feeder against a character-stream model of the
// screen (expected character queue plus cursor), with a done-pulsing controller responder.
module tb_oled_text_feeder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  oled_text_feeder_if #(.POSW(6), .LEVW(5)) bus ();

  oled_text_feeder #(
    .DEPTH (16),
    .COLS  (16),
    .ROWS  (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int         checks    = 0;
  int         errors    = 0;
  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];
  int         modelPos  = 0;
  int         doneDelay = 5;
  bit         stallDone = 1'b1;
  bit         randDelay = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Screen model: every emitted character lands at the cursor, which wraps after the last cell.
  task automatic emitChar(input logic [7:0] c);
    expQ.push_back(c);
    modelPos = (modelPos + 1) % 64;
  endtask

  task automatic modelByte(input logic [7:0] b);
    int n;
    n = 0;
    if (b >= 8'h20 && b <= 8'h7E) emitChar(b);
    else if (b == 8'h0A) n = (modelPos % 16 == 0) ? 0 : 16 - (modelPos % 16);
    else if (b == 8'h0C) n = (modelPos == 0) ? 0 : 64 - modelPos;
    repeat (n) emitChar(8'h20);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (bus.ready !== 1'b1) checkOutput("ready_timeout", 32'(bus.ready), 32'd1);
    else begin
      bus.data  = b;
      bus.valid = 1'b1;
      @(posedge clk);
      #1 bus.valid = 1'b0;
      modelByte(b);
    end
  endtask

  task automatic waitDrain(input string tag);
    int t;
    int quiet;
    int n;
    t     = 0;
    quiet = 0;
    while (quiet < 10 && t < 8000) begin
      @(negedge clk);
      t++;
      if (bus.level == 0 && !bus.oled_data_valid && rxQ.size() == expQ.size()) quiet++;
      else quiet = 0;
    end
    checkOutput({tag, "_count"}, 32'(rxQ.size()), 32'(expQ.size()));
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "_char"}, 32'(rxQ[i]), 32'(expQ[i]));
    checkOutput({tag, "_pos"}, 32'(bus.pos), 32'(modelPos));
    checkOutput({tag, "_level"}, 32'(bus.level), 32'd0);
    rxQ.delete();
    expQ.delete();
  endtask

  // Controller model: after valid is seen, wait a few cycles, raise done until valid drops.
  initial begin : responder
    logic [7:0] held;
    int         d;
    bus.done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.oled_data_valid === 1'b1 && !stallDone) begin
        held = bus.oled_data;
        d    = randDelay ? int'($urandom_range(0, 4)) : doneDelay;
        repeat (d) begin
          @(negedge clk);
          checkOutput("data_stable", 32'(bus.oled_data), 32'(held));
        end
        @(posedge clk);
        #1 bus.done = 1'b1;
        for (int t = 0; t < 50 && bus.oled_data_valid; t++) @(negedge clk);
        checkOutput("valid_release", 32'(bus.oled_data_valid), 32'd0);
        bus.done = 1'b0;
        rxQ.push_back(held);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] b;
    int         r;
    int         t;

    bus.data  = 8'h00;
    bus.valid = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(bus.ready), 32'd0);
    checkOutput("rst_valid", 32'(bus.oled_data_valid), 32'd0);
    checkOutput("rst_data", 32'(bus.oled_data), 32'd0);
    checkOutput("rst_pos", 32'(bus.pos), 32'd0);
    checkOutput("rst_level", 32'(bus.level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("ready_after_rst", 32'(bus.ready), 32'd1);
    stallDone = 1'b0;

    // Single character with latency observed edge by edge after the write edge.
    @(negedge clk);
    bus.data  = 8'h41;
    bus.valid = 1'b1;
    @(posedge clk);
    #1 bus.valid = 1'b0;
    modelByte(8'h41);
    @(posedge clk);
    #1 checkOutput("lat_n1", 32'(bus.oled_data_valid), 32'd0);
    @(posedge clk);
    #1 checkOutput("lat_n2", 32'(bus.oled_data_valid), 32'd0);
    @(posedge clk);
    #1 checkOutput("lat_n3", 32'(bus.oled_data_valid), 32'd1);
    checkOutput("lat_data", 32'(bus.oled_data), 32'h41);
    waitDrain("single");
    checkOutput("single_pos1", 32'(bus.pos), 32'd1);

    applyStimulus(8'h0C);
    waitDrain("ff_pos1");

    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h0A);
    waitDrain("lf_pad");
    checkOutput("lf_pos16", 32'(bus.pos), 32'd16);
    applyStimulus(8'h0A);
    waitDrain("lf_col0");

    applyStimulus(8'h0C);
    for (int i = 0; i < 5; i++) applyStimulus(8'h61 + 8'(i));
    waitDrain("to_pos5");
    applyStimulus(8'h0C);
    waitDrain("ff_pos5");

    for (int i = 0; i < 64; i++) applyStimulus(8'($urandom_range(32, 126)));
    waitDrain("wrap64");
    checkOutput("wrap_pos0", 32'(bus.pos), 32'd0);

    applyStimulus(8'h30);
    applyStimulus(8'h07);
    applyStimulus(8'h1B);
    applyStimulus(8'h7F);
    waitDrain("dropped");

    // Backpressure: controller never answers, so one byte sits in ACK and sixteen fill the FIFO.
    stallDone = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      checkOutput("bp_ready", 32'(bus.ready), 32'd1);
      b         = 8'($urandom_range(32, 126));
      bus.data  = b;
      bus.valid = 1'b1;
      modelByte(b);
    end
    @(negedge clk);
    bus.data = 8'h21;
    checkOutput("bp_full_ready", 32'(bus.ready), 32'd0);
    checkOutput("bp_full_level", 32'(bus.level), 32'd16);
    @(negedge clk);
    bus.valid = 1'b0;
    checkOutput("bp_ignored_level", 32'(bus.level), 32'd16);
    stallDone = 1'b0;
    waitDrain("backpressure");

    randDelay = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       b = 8'($urandom_range(32, 126));
      else if (r == 7) b = 8'h0A;
      else if (r == 8) b = 8'h0C;
      else             b = 8'($urandom_range(127, 255));
      applyStimulus(b);
    end
    waitDrain("random");

    // Reset while a character is being requested and another byte is buffered.
    if (modelPos == 0) begin
      applyStimulus(8'h50);
      waitDrain("pre_reset");
    end
    stallDone = 1'b1;
    applyStimulus(8'h5A);
    t = 0;
    while (bus.oled_data_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checkOutput("midack_valid", 32'(bus.oled_data_valid), 32'd1);
    applyStimulus(8'h59);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midack_rst_valid", 32'(bus.oled_data_valid), 32'd0);
    checkOutput("midack_rst_pos", 32'(bus.pos), 32'd0);
    checkOutput("midack_rst_level", 32'(bus.level), 32'd0);
    checkOutput("midack_rst_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    rxQ.delete();
    modelPos  = 0;
    randDelay = 1'b0;
    stallDone = 1'b0;
    applyStimulus(8'h51);
    waitDrain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
